// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Width of each per-producer grant statistics counter.
    localparam int GNT_CNT_W = 16;

    // Round-robin successor of idx among n producers.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/fifo_rr_picker.sv
// Combinational round-robin picker: first set bit of req at or after rr_ptr,
// wrapping modulo NUM_REQ. Returns the one-hot pick and its index.
module fifo_rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         pick,
    output logic [$clog2(NUM_REQ)-1:0] pick_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Scan from rr_ptr upward; the first requester found wins.
    always_comb begin
        int   idx;
        logic found;
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        idx      = int'(rr_ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[IDX_W'(idx)]) begin
                found    = 1'b1;
                pick_idx = IDX_W'(idx);
            end
            idx = rr_next(idx, NUM_REQ);
        end
        if (found) begin
            pick[pick_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-level round-robin arbiter sharing one FIFO write port among
// NUM_REQ producers. Grants are withheld whenever the issued beat could
// overflow the FIFO. Optional per-producer grant counters are built when
// the FIFO_ARB_STATS_EN macro is defined; otherwise gnt_cnt_flat is 0.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DROP_CNT_W = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_last,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [FIFO_WIDTH-1:0]           fifo_data_in,
    output logic                            fifo_wr_en,
    input  logic                            fifo_full,
    input  logic                            fifo_almostfull,
    input  logic                            fifo_overflow,
    output logic [$clog2(NUM_REQ)-1:0]      owner,
    output logic                            busy,
    output logic [DROP_CNT_W-1:0]           drop_cnt,
    output logic [NUM_REQ*GNT_CNT_W-1:0]    gnt_cnt_flat
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Elaboration-time sizing sanity checks.
    if (NUM_REQ < 2 || NUM_REQ > 8 || FIFO_DEPTH < 2) begin : g_bad_params
        $error("fifo_wr_arbiter: unsupported NUM_REQ or FIFO_DEPTH");
    end

    arb_state_t             state_reg, state_next;
    logic [IDX_W-1:0]       rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]       owner_reg, owner_next;
    logic [NUM_REQ-1:0]     pick;
    logic [IDX_W-1:0]       pick_idx;
    logic                   stall;
    logic [FIFO_WIDTH-1:0]  fifo_data_reg;
    logic                   fifo_wr_en_reg;
    logic [DROP_CNT_W-1:0]  drop_cnt_reg;
    logic [FIFO_WIDTH-1:0]  data_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign data_arr[gi] = req_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
        end
    endgenerate

    fifo_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req      (req),
        .rr_ptr   (rr_ptr_reg),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    // A beat issued now lands one edge after the in-flight write, so
    // almostfull only blocks when a write is already in flight.
    assign stall = fifo_full | (fifo_almostfull & fifo_wr_en_reg);

    // Next-state, grant and pointer logic.
    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        owner_next  = owner_reg;
        gnt         = '0;
        if (!rst && !stall) begin
            case (state_reg)
                ARB_IDLE: begin
                    if (|req) begin
                        gnt        = pick;
                        owner_next = pick_idx;
                        if (req_last[pick_idx]) begin
                            rr_ptr_next = IDX_W'(rr_next(int'(pick_idx), NUM_REQ));
                        end else begin
                            state_next = ARB_LOCKED;
                        end
                    end
                end
                ARB_LOCKED: begin
                    // Lock holds even if the owner goes quiet mid-packet.
                    if (req[owner_reg]) begin
                        gnt[owner_reg] = 1'b1;
                        if (req_last[owner_reg]) begin
                            state_next  = ARB_IDLE;
                            rr_ptr_next = IDX_W'(rr_next(int'(owner_reg), NUM_REQ));
                        end
                    end
                end
            endcase
        end
    end

    // Arbiter state, round-robin pointer and owner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ARB_IDLE;
            rr_ptr_reg <= '0;
            owner_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            owner_reg  <= owner_next;
        end
    end

    // Register the granted beat onto the FIFO write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wr_en_reg <= 1'b0;
            fifo_data_reg  <= '0;
        end else begin
            fifo_wr_en_reg <= |gnt;
            if (|gnt) begin
                fifo_data_reg <= data_arr[owner_next];
            end
        end
    end

    // Saturating count of cycles with the FIFO overflow flag raised.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_reg <= '0;
        end else if (fifo_overflow && !(&drop_cnt_reg)) begin
            drop_cnt_reg <= drop_cnt_reg + 1'b1;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
            logic [GNT_CNT_W-1:0] cnt_reg;
            // Saturating grant counter for producer gi.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (gnt[gi] && !(&cnt_reg)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            assign gnt_cnt_flat[gi*GNT_CNT_W +: GNT_CNT_W] = cnt_reg;
        end
    endgenerate
`else
    assign gnt_cnt_flat = '0;
`endif

    assign fifo_wr_en   = fifo_wr_en_reg;
    assign fifo_data_in = fifo_data_reg;
    assign owner        = owner_reg;
    assign busy         = (state_reg == ARB_LOCKED) | fifo_wr_en_reg;
    assign drop_cnt     = drop_cnt_reg;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the write port of one synchronous FIFO (FIFO_WIDTH × FIFO_DEPTH) between NUM_REQ producers.
- Round-robin arbitration on packet boundaries: once a producer wins, it keeps the grant until its last beat.
- Registers the winning beat onto the FIFO write port.
- Back-pressures from the FIFO full/almostfull flags so no beat it issues can overflow.

Parameters:
- NUM_REQ, 4: number of producers (2..8).
- FIFO_WIDTH, 16: data width of each beat.
- FIFO_DEPTH, 8: depth of the downstream FIFO; used only for sizing checks.
- DROP_CNT_W, 8: width of the overflow-event counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-producer request; beat valid.
- req_last  in  NUM_REQ  per-producer flag: the current beat ends the packet.
- req_data  in  NUM_REQ*FIFO_WIDTH  flattened beats; producer i owns bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- gnt  out  NUM_REQ  one-hot, combinational; the beat of producer i is accepted at this clock edge.
- fifo_data_in  out  FIFO_WIDTH  registered beat to the FIFO.
- fifo_wr_en  out  1  registered FIFO write enable.
- fifo_full  in  1  FIFO full flag.
- fifo_almostfull  in  1  FIFO flag: count == FIFO_DEPTH-1.
- fifo_overflow  in  1  FIFO overflow flag.
- owner  out  $clog2(NUM_REQ)  index of the current or last winner.
- busy  out  1  high when state is ARB_LOCKED or fifo_wr_en is high.
- drop_cnt  out  DROP_CNT_W  saturating count of cycles with fifo_overflow high.
- gnt_cnt_flat  out  NUM_REQ*16  per-producer grant statistics (optional feature).

Behaviour:
- Reset values:
  - state = ARB_IDLE, rr_ptr = 0, owner = 0.
  - fifo_wr_en = 0, fifo_data_in = 0, drop_cnt = 0, gnt_cnt_flat = 0.
  - gnt = 0 during the reset cycle.
  - Reset mid-packet abandons the packet; there is no recovery beat.
- Stall:
  - stall = fifo_full | (fifo_almostfull & fifo_wr_en).
  - This is exact: the beat issued at edge t lands at edge t+1, after the in-flight write.
  - While stall is high, gnt = 0.
- ARB_IDLE:
  - Winner = first set bit of req, scanning rr_ptr, rr_ptr+1, ... with modulo NUM_REQ wrap.
  - If !stall and any req: gnt[winner] = 1 and owner <= winner.
  - If req_last[winner]: stay in ARB_IDLE and set rr_ptr <= winner+1 (mod NUM_REQ).
  - Otherwise: go to ARB_LOCKED.
- ARB_LOCKED:
  - Only owner may be granted; gnt[owner] = req[owner] & !stall.
  - Accepted beat with req_last[owner]: go to ARB_IDLE and set rr_ptr <= owner+1.
  - Owner deasserting req mid-packet: hold the lock indefinitely; other producers stay blocked.
- Datapath:
  - On any gnt: fifo_wr_en <= 1 and fifo_data_in <= winning req_data slice.
  - Otherwise fifo_wr_en <= 0 and fifo_data_in holds its value.
  - Latency: acceptance edge t → fifo_wr_en high during cycle t+1. Throughput is 1 beat/cycle when not stalled.
- Simultaneous events:
  - Single-beat packets (req_last=1) from several producers rotate one per cycle.
  - The packet-end edge may also grant in ARB_IDLE on the next cycle only; there is no same-cycle re-grant.
- drop_cnt: +1 per cycle with fifo_overflow=1; saturates at all-ones. Non-zero indicates a protocol bug.

Optional Feature:
- FIFO_ARB_STATS_EN defined:
  - One 16-bit saturating counter per producer, +1 on each gnt bit.
  - Counter i occupies gnt_cnt_flat[i*16 +: 16]; all counters clear on rst.
- FIFO_ARB_STATS_EN undefined:
  - gnt_cnt_flat is tied to 0.
  - No counter flops are synthesized.

Decomposition:
- Package fifo_arb_pkg:
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t.
  - GNT_CNT_W = 16.
  - Function rr_next(idx, n) returning (idx+1) mod n.
- Sub-module fifo_rr_picker: purely combinational; inputs req and rr_ptr; outputs one-hot pick and its index. Instantiated once.

Test Plan:
- Reset, then req=4'b1111, all req_last=1, FIFO never full → gnt sequence 0001, 0010, 0100, 1000, 0001; fifo_wr_en high one cycle after each; data matches the granted slice.
- Producer 2 sends a 3-beat packet (data 0xA0, 0xA1, 0xA2, last on beat 3) while req[0]=1 → gnt[2] for 3 consecutive cycles, then gnt[0]; FIFO order A0, A1, A2, then producer 0's beat.
- Continuous single-beat writes with no reads into the FIFO (FIFO_DEPTH=8) → exactly 8 writes, then gnt=0 while full; fifo_overflow never asserts; drop_cnt stays 0.
- Almostfull case: FIFO count=7 with a write in flight → no gnt that cycle; with no write in flight → one gnt, then full.
- Assert rst mid-packet (owner=1, state ARB_LOCKED) → next cycle state=ARB_IDLE, gnt follows rr_ptr=0; fifo_wr_en=0 in the cycle after reset.
- With FIFO_ARB_STATS_EN: 10 grants to producer 3 → gnt_cnt_flat[63:48]=10. Without the macro: gnt_cnt_flat stays 0.
